// File: rtl/mdu_unit_if.sv
// E-stage multiply/divide operand and result bundle shared by the MDU and its driver.
// The driver owns opcode and operands; the MDU owns the busy flag and HI/LO views.
interface mdu_unit_if;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_Busy;
  logic [31:0] E_HILOOut;
  logic [31:0] HI_out;
  logic [31:0] LO_out;

  modport master (
    output E_MDOp, E_A, E_B,
    input  E_Busy, E_HILOOut, HI_out, LO_out
  );

  modport slave (
    input  E_MDOp, E_A, E_B,
    output E_Busy, E_HILOOut, HI_out, LO_out
  );
endinterface

// File: rtl/mdu_unit.sv
// HI/LO multiply/divide unit; result commits MULT_CYCLES/DIV_CYCLES edges after start.
// No backpressure input: E_Busy asks the stall unit to hold HI/LO ops. MDU_MADD_EN adds MADD/MSUB.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave md
);

  localparam int CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  logic [31:0]      hi_reg, lo_reg, pend_hi, pend_lo;
  logic             pend_wr, busy_reg;
  logic [CNT_W-1:0] cnt;

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s;
  logic [31:0] res_hi, res_lo;
  logic        res_wr, is_mul, is_div, start;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign a_sx   = {{32{md.E_A[31]}}, md.E_A};
  assign b_sx   = {{32{md.E_B[31]}}, md.E_B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, md.E_A} * {32'd0, md.E_B};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  assign a_mag = md.E_A[31] ? -md.E_A : md.E_A;
  assign b_mag = md.E_B[31] ? -md.E_B : md.E_B;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (md.E_A[31] ^ md.E_B[31]) ? -q_mag : q_mag;
  assign r_s   = md.E_A[31] ? -r_mag : r_mag;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b1;
    case (md.E_MDOp)
      OP_MULT:  begin is_mul = 1'b1; {res_hi, res_lo} = prod_s; end
      OP_MULTU: begin is_mul = 1'b1; {res_hi, res_lo} = prod_u; end
      OP_DIV:   begin is_div = 1'b1; res_wr = |md.E_B; res_hi = r_s; res_lo = q_s; end
      OP_DIVU:  begin
        is_div = 1'b1;
        res_wr = |md.E_B;
        res_hi = md.E_A % md.E_B;
        res_lo = md.E_A / md.E_B;
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul = 1'b1; {res_hi, res_lo} = {hi_reg, lo_reg} + prod_s; end
      OP_MADDU: begin is_mul = 1'b1; {res_hi, res_lo} = {hi_reg, lo_reg} + prod_u; end
      OP_MSUB:  begin is_mul = 1'b1; {res_hi, res_lo} = {hi_reg, lo_reg} - prod_s; end
      OP_MSUBU: begin is_mul = 1'b1; {res_hi, res_lo} = {hi_reg, lo_reg} - prod_u; end
`endif
      default: ;
    endcase
  end

  assign start = ~busy_reg & (is_mul | is_div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg   <= 32'd0;
      lo_reg   <= 32'd0;
      pend_hi  <= 32'd0;
      pend_lo  <= 32'd0;
      pend_wr  <= 1'b0;
      busy_reg <= 1'b0;
      cnt      <= '0;
    end else if (busy_reg) begin
      // Opcodes arriving while busy are dropped; only the countdown advances.
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy_reg <= 1'b0;
        if (pend_wr) begin
          hi_reg <= pend_hi;
          lo_reg <= pend_lo;
        end
      end
    end else if (start) begin
      pend_hi  <= res_hi;
      pend_lo  <= res_lo;
      pend_wr  <= res_wr;
      busy_reg <= 1'b1;
      cnt      <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (md.E_MDOp == OP_MTHI) begin
      hi_reg <= md.E_A;
    end else if (md.E_MDOp == OP_MTLO) begin
      lo_reg <= md.E_A;
    end
  end

  assign md.E_Busy    = start | busy_reg;
  assign md.E_HILOOut = (md.E_MDOp == OP_MFHI) ? hi_reg :
                        (md.E_MDOp == OP_MFLO) ? lo_reg : 32'd0;
  assign md.HI_out    = hi_reg;
  assign md.LO_out    = lo_reg;

endmodule
